// File: rtl/align_shifter_pkg.sv
// Shared definitions for align_shifter: operation encoding, parameter limits
// and the per-level shift distance helper.
package align_shifter_pkg;

  typedef enum logic [1:0] {
    OP_LSR = 2'b00,
    OP_ASR = 2'b01,
    OP_LSL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam int MIN_WIDTH = 2;
  localparam int MIN_SPLIT = 1;

  // Distance of the level driven by amt bit bit_idx. Anything at or beyond
  // width behaves identically, so large bits collapse to width.
  function automatic int level_dist(input int bit_idx, input int width);
    return (bit_idx >= 30) ? width : (1 << bit_idx);
  endfunction

endpackage

// File: rtl/align_shifter_shift_level.sv
// One combinational barrel-shifter level: shifts by DIST when i_sel is set.
// The lost-bit output exists only when ALIGN_SHIFTER_STICKY_EN is defined.
module shift_level #(
  parameter int WIDTH = 23,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sel,
  input  logic             i_fill,
  input  logic             i_left,
  output logic [WIDTH-1:0] o_data
`ifdef ALIGN_SHIFTER_STICKY_EN
  ,
  output logic             o_lost
`endif
);

  logic [WIDTH-1:0] w_right;
  logic [WIDTH-1:0] w_left;
`ifdef ALIGN_SHIFTER_STICKY_EN
  logic             w_lost_bits;
`endif

  generate
    if (DIST >= WIDTH) begin : g_sat
      // Every bit leaves the word: result is pure fill.
      assign w_right = {WIDTH{i_fill}};
      assign w_left  = {WIDTH{i_fill}};
`ifdef ALIGN_SHIFTER_STICKY_EN
      assign w_lost_bits = |i_data;
`endif
    end else begin : g_part
      assign w_right = {{DIST{i_fill}}, i_data[WIDTH-1:DIST]};
      assign w_left  = {i_data[WIDTH-1-DIST:0], {DIST{i_fill}}};
`ifdef ALIGN_SHIFTER_STICKY_EN
      assign w_lost_bits = |i_data[DIST-1:0];
`endif
    end
  endgenerate

  assign o_data = !i_sel ? i_data : (i_left ? w_left : w_right);

`ifdef ALIGN_SHIFTER_STICKY_EN
  // Only right shifts contribute to sticky.
  assign o_lost = i_sel & ~i_left & w_lost_bits;
`endif

endmodule

// File: rtl/align_shifter.sv
// Two-stage pipelined LSR/ASR/LSL shifter with valid/ready on both sides.
// Define ALIGN_SHIFTER_STICKY_EN to generate the sticky (lost-bit OR) output.
module align_shifter
  import align_shifter_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int AMT_W = 8,
  parameter int SPLIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);

  localparam int HI_W = AMT_W - SPLIT;

  generate
    if (WIDTH < MIN_WIDTH || SPLIT < MIN_SPLIT || SPLIT > AMT_W - 1) begin : g_param_check
      $error("align_shifter: WIDTH must be >= 2 and SPLIT within 1..AMT_W-1");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A stage loads when it is empty or its content moves on in that edge;
  // in_ready depends only on pipeline state, never on in_valid.
  logic w_s2_load;
  logic w_in_fire;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [HI_W-1:0]  r_s1_amt_hi;
  op_e              r_s1_op;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;

  op_e              w_in_op;
  logic             w_s1_fill;
  logic             w_s1_left;
  logic             w_s2_fill;
  logic             w_s2_left;
  logic [SPLIT:0][WIDTH-1:0] w_s1_chain;
  logic [HI_W:0][WIDTH-1:0]  w_s2_chain;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = rst_n && (!r_s1_valid || w_s2_load);
  assign w_in_fire = in_valid && in_ready;

  assign w_in_op   = op_e'(in_op);
  assign w_s1_fill = (w_in_op == OP_ASR) && in_data[WIDTH-1];
  assign w_s1_left = (w_in_op == OP_LSL);
  // After a partial ASR the MSB still holds the sign, so it is a valid fill.
  assign w_s2_fill = (r_s1_op == OP_ASR) && r_s1_data[WIDTH-1];
  assign w_s2_left = (r_s1_op == OP_LSL);

`ifdef ALIGN_SHIFTER_STICKY_EN
  logic [SPLIT-1:0] w_s1_lost;
  logic [HI_W-1:0]  w_s2_lost;
`endif

  assign w_s1_chain[0] = in_data;
  assign w_s2_chain[0] = r_s1_data;

  genvar gi;
  generate
    for (gi = 0; gi < SPLIT; gi++) begin : g_s1
      shift_level #(
        .WIDTH (WIDTH),
        .DIST  (level_dist(gi, WIDTH))
      ) u_level (
        .i_data (w_s1_chain[gi]),
        .i_sel  (in_amt[gi]),
        .i_fill (w_s1_fill),
        .i_left (w_s1_left),
        .o_data (w_s1_chain[gi+1])
`ifdef ALIGN_SHIFTER_STICKY_EN
        ,
        .o_lost (w_s1_lost[gi])
`endif
      );
    end
    for (gi = 0; gi < HI_W; gi++) begin : g_s2
      // Levels at or beyond WIDTH saturate, which covers amt >= WIDTH.
      shift_level #(
        .WIDTH (WIDTH),
        .DIST  (level_dist(gi + SPLIT, WIDTH))
      ) u_level (
        .i_data (w_s2_chain[gi]),
        .i_sel  (r_s1_amt_hi[gi]),
        .i_fill (w_s2_fill),
        .i_left (w_s2_left),
        .o_data (w_s2_chain[gi+1])
`ifdef ALIGN_SHIFTER_STICKY_EN
        ,
        .o_lost (w_s2_lost[gi])
`endif
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_amt_hi <= '0;
      r_s1_op     <= OP_LSR;
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (w_in_fire) begin
          r_s1_data   <= w_s1_chain[SPLIT];
          r_s1_amt_hi <= in_amt[AMT_W-1:SPLIT];
          r_s1_op     <= w_in_op;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_s2_chain[HI_W];
        end
      end
    end
  end

`ifdef ALIGN_SHIFTER_STICKY_EN
  logic r_s1_sticky;
  logic r_s2_sticky;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_sticky <= 1'b0;
      r_s2_sticky <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_sticky <= |w_s1_lost;
      end
      if (w_s2_load && r_s1_valid) begin
        r_s2_sticky <= r_s1_sticky | (|w_s2_lost);
      end
    end
  end

  assign out_sticky = r_s2_sticky;
`else
  assign out_sticky = 1'b0;
`endif

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;

endmodule

// File: tb/tb_align_shifter.sv
// Self-checking bench for align_shifter: directed corner cases, backpressure,
// mid-stream reset and a long randomized run against a behavioural model.
module tb_align_shifter;

  localparam int W  = 23;
  localparam int AW = 8;
`ifdef ALIGN_SHIFTER_STICKY_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sticky;

  align_shifter #(.WIDTH(W), .AMT_W(AW), .SPLIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   last_out = '0;
  bit           saw_stall = 1'b0;
  bit           rand_done = 1'b0;

  function automatic logic [W:0] ref_model(input logic [W-1:0] d,
                                           input logic [AW-1:0] a,
                                           input logic [1:0] op);
    logic signed [W-1:0] sd;
    logic signed [W-1:0] st;
    logic [W-1:0]        r;
    logic                s;
    longint unsigned     mask;
    sd = d;
    st = sd >>> a;
    case (op)
      2'b01:   r = st;
      2'b10:   r = d << a;
      default: r = d >> a;
    endcase
    if (op == 2'b10 || !STK_EN) s = 1'b0;
    else if (a >= W)            s = |d;
    else begin
      mask = (64'd1 << a) - 64'd1;
      s    = |(64'(d) & mask);
    end
    return {s, r};
  endfunction

  function automatic void check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sticky/data=%h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_val(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: records accepted requests and checks every delivered result.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got sticky/data=%h with empty queue", {out_sticky, out_data});
        end else begin
          check("scoreboard", {out_sticky, out_data}, exp_q.pop_front());
        end
        last_out = {out_sticky, out_data};
      end else if (!out_valid) begin
        check("hold_idle", {out_sticky, out_data}, last_out);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_data, in_amt, in_op));
      if (in_valid && !in_ready) saw_stall = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] op);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0d required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 200);
  endtask

  task automatic send_check(input string name, input logic [W-1:0] d, input logic [AW-1:0] a,
                            input logic [1:0] op, input logic [W-1:0] exp_d, input logic exp_s);
    int cyc;
    out_ready = 1'b1;
    send(d, a, op);
    in_valid = 1'b0;
    wait_out(cyc);
    check(name, {out_sticky, out_data}, {exp_s, exp_d});
    check_val({name, "_latency"}, cyc, 2);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_val({name, "_drain_left"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = 2'b00;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_out_valid", out_valid, 0);
    check_val("reset_in_ready", in_ready, 0);
    check("reset_out", {out_sticky, out_data}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    send_check("lsr_1",      23'h400001, 8'd1,   2'b00, 23'h200000, STK_EN);
    send_check("asr_30",     23'h400000, 8'd30,  2'b01, 23'h7FFFFF, STK_EN);
    send_check("lsl_21",     23'h000003, 8'd21,  2'b10, 23'h600000, 1'b0);
    send_check("lsr_8",      23'h7FFFFF, 8'd8,   2'b00, 23'h007FFF, STK_EN);
    send_check("amt_zero",   23'h123456, 8'd0,   2'b01, 23'h123456, 1'b0);
    send_check("op_rsv",     23'h5A5A5A, 8'd4,   2'b11, 23'h05A5A5, STK_EN);
    send_check("lsr_width",  23'h400000, 8'd23,  2'b00, 23'h000000, STK_EN);
    send_check("lsr_w_m1",   23'h400000, 8'd22,  2'b00, 23'h000001, 1'b0);
    send_check("asr_pos_sat",23'h3FFFFF, 8'd200, 2'b01, 23'h000000, STK_EN);
    send_check("lsl_sat",    23'h7FFFFF, 8'd255, 2'b10, 23'h000000, 1'b0);

    // Back-to-back burst with a four-cycle output stall.
    saw_stall = 1'b0;
    fork
      begin
        for (int c = 1; c <= 8; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 8; k++)
          send(W'($urandom), AW'($urandom_range(0, 40)), 2'($urandom_range(0, 3)));
        in_valid = 1'b0;
      end
    join
    drain("burst");
    check_val("burst_in_ready_dropped", int'(saw_stall), 1);

    // Reset with both stages full and the consumer stalled.
    out_ready = 1'b0;
    send(23'h1234AB, 8'd3, 2'b00);
    send(23'h7654CD, 8'd5, 2'b01);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check_val("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check_val("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_release_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("midrst_no_stale", exp_q.size(), 0);

    // Long randomized run with random valid and backpressure.
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 10000; k++) begin
          if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(W'($urandom), AW'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
        end
        in_valid  = 1'b0;
        rand_done = 1'b1;
      end
    join
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
